// File: rtl/reset_pkg.sv
// Shared state encodings, reset-cause codes and sizing helper for the reset sequencer.
package reset_pkg;

  typedef logic [2:0] state_t;

  localparam logic [2:0] S_WAIT_LOCK = 3'd0;
  localparam logic [2:0] S_STABLE    = 3'd1;
  localparam logic [2:0] S_PERIPH    = 3'd2;
  localparam logic [2:0] S_RUN       = 3'd3;
  localparam logic [2:0] S_HOLD      = 3'd4;

  typedef logic [1:0] reset_cause_t;

  localparam reset_cause_t CAUSE_POR    = 2'b00;
  localparam reset_cause_t CAUSE_LOCK   = 2'b01;
  localparam reset_cause_t CAUSE_BUTTON = 2'b10;
  localparam reset_cause_t CAUSE_SW     = 2'b11;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/reset_sequencer_debouncer.sv
// Button input: 2-FF synchroniser followed by a stability counter; emits the
// debounced level and a one-cycle pulse when the level rises.
module debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             meta;
  logic             sync;
  logic [CNT_W-1:0] cnt;

  // Level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta  <= 1'b0;
      sync  <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
    end else begin
      meta <= raw;
      sync <= meta;
      rise <= 1'b0;
      if (sync == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt   <= '0;
        level <= sync;
        rise  <= sync;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/reset_sequencer.sv
// Ordered reset release: waits for a stable PLL lock, frees peripherals, then the CPU;
// re-sequences on lock loss, debounced button or software request and records why.
module reset_sequencer
  import reset_pkg::*;
#(
  parameter int unsigned LOCK_STABLE_CYCLES   = 1024,
  parameter int unsigned PERIPH_TO_CPU_CYCLES = 16,
  parameter int unsigned MIN_RESET_CYCLES     = 64,
  parameter int unsigned DEBOUNCE_CYCLES      = 1_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pll_locked,
  input  logic       btn_reset,
  input  logic       sw_reset_req,
  output logic       periph_rst_n,
  output logic       cpu_rst_n,
  output logic       ready,
  output logic [1:0] reset_cause
);

  localparam int unsigned CNT_MAX =
    max3(LOCK_STABLE_CYCLES, PERIPH_TO_CPU_CYCLES, MIN_RESET_CYCLES);
  localparam int unsigned CNT_W = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] PERIPH_LAST = CNT_W'(PERIPH_TO_CPU_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(MIN_RESET_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  reset_cause_t     cause_d;
  logic             lock_meta, locked_s;
  logic             btn_level, btn_rise;

  debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_debounce (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (btn_reset),
    .level (btn_level),
    .rise  (btn_rise)
  );

  // State, counter and outputs; outputs follow the next state on the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lock_meta    <= 1'b0;
      locked_s     <= 1'b0;
      state_q      <= S_WAIT_LOCK;
      cnt_q        <= '0;
      periph_rst_n <= 1'b0;
      cpu_rst_n    <= 1'b0;
      ready        <= 1'b0;
      reset_cause  <= CAUSE_POR;
    end else begin
      lock_meta    <= pll_locked;
      locked_s     <= lock_meta;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      periph_rst_n <= (state_d == S_PERIPH) || (state_d == S_RUN);
      cpu_rst_n    <= (state_d == S_RUN);
      ready        <= (state_d == S_RUN);
      reset_cause  <= cause_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cause_d = reset_cause;
    case (state_q)
      S_WAIT_LOCK: begin
        cnt_d = '0;
        if (locked_s) state_d = S_STABLE;
      end
      S_STABLE: begin
        if (!locked_s) begin
          state_d = S_WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == LOCK_LAST) begin
          state_d = S_PERIPH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_PERIPH: begin
        if (!locked_s) begin
          state_d = S_WAIT_LOCK;
          cnt_d   = '0;
          cause_d = CAUSE_LOCK;
        end else if (cnt_q == PERIPH_LAST) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RUN: begin
        // Lock loss outranks the button, which outranks software.
        cnt_d = '0;
        if (!locked_s) begin
          state_d = S_WAIT_LOCK;
          cause_d = CAUSE_LOCK;
        end else if (btn_rise) begin
          state_d = S_HOLD;
          cause_d = CAUSE_BUTTON;
        end else if (sw_reset_req) begin
          state_d = S_HOLD;
          cause_d = CAUSE_SW;
        end
      end
      S_HOLD: begin
        // Saturate, then wait for the button to be released.
        if (cnt_q == HOLD_LAST) begin
          if (!btn_level) begin
            state_d = S_WAIT_LOCK;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_WAIT_LOCK;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: timestamp-based behavioural model checked every cycle,
// directed scenarios with literal timing expectations, then randomized stimulus.
module tb_reset_sequencer;

  localparam int L = 8;
  localparam int P = 4;
  localparam int M = 64;
  localparam int D = 16;

  logic       clk = 1'b0;
  logic       rst_n, pll_locked, btn_reset, sw_reset_req;
  logic       periph_rst_n, cpu_rst_n, ready;
  logic [1:0] reset_cause;

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;

  reset_sequencer #(
    .LOCK_STABLE_CYCLES  (L),
    .PERIPH_TO_CPU_CYCLES(P),
    .MIN_RESET_CYCLES    (M),
    .DEBOUNCE_CYCLES     (D)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pll_locked   (pll_locked),
    .btn_reset    (btn_reset),
    .sw_reset_req (sw_reset_req),
    .periph_rst_n (periph_rst_n),
    .cpu_rst_n    (cpu_rst_n),
    .ready        (ready),
    .reset_cause  (reset_cause)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: the sequence is described by timestamps rather than a counter.
  // mode 0 = waiting for lock, 1 = sequence armed at edge t0, 2 = held since edge h0.
  int         edge_n = 0;
  int         mode = 0;
  int         t0 = 0;
  int         h0 = 0;
  int         a_pre;
  int         run_len = 0;
  bit         hist_l1 = 0, hist_l2 = 0, hist_b1 = 0, hist_b2 = 0;
  bit         m_deb = 0, m_rise = 0;
  bit         ls, rise_pre, deb_pre;
  logic [1:0] m_cause = 2'b00;
  bit         e_periph = 0, e_cpu = 0, e_ready = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      edge_n = 0; mode = 0; run_len = 0;
      hist_l1 = 0; hist_l2 = 0; hist_b1 = 0; hist_b2 = 0;
      m_deb = 0; m_rise = 0; m_cause = 2'b00;
    end else begin
      edge_n++;
      ls = hist_l2;
      rise_pre = m_rise;
      deb_pre = m_deb;
      case (mode)
        0: if (ls) begin mode = 1; t0 = edge_n; end
        1: begin
          a_pre = edge_n - 1 - t0;
          if (!ls) begin
            if (a_pre >= L) m_cause = 2'b01;
            mode = 0;
          end else if (a_pre >= L + P) begin
            if (rise_pre) begin mode = 2; h0 = edge_n; m_cause = 2'b10; end
            else if (sw_reset_req) begin mode = 2; h0 = edge_n; m_cause = 2'b11; end
          end
        end
        default: if (edge_n - h0 >= M && !deb_pre) mode = 0;
      endcase
      m_rise = 0;
      if (hist_b2 == m_deb) run_len = 0;
      else begin
        run_len++;
        if (run_len == D) begin m_deb = !m_deb; run_len = 0; m_rise = m_deb; end
      end
      hist_l2 = hist_l1; hist_l1 = pll_locked;
      hist_b2 = hist_b1; hist_b1 = btn_reset;
    end
    e_periph = (mode == 1) && (edge_n - t0 >= L);
    e_cpu    = (mode == 1) && (edge_n - t0 >= L + P);
    e_ready  = e_cpu;
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("periph_rst_n", 4'(periph_rst_n), 4'(e_periph));
      check("cpu_rst_n", 4'(cpu_rst_n), 4'(e_cpu));
      check("ready", 4'(ready), 4'(e_ready));
      check("reset_cause", 4'(reset_cause), 4'(m_cause));
      check("cpu_before_periph", 4'(cpu_rst_n & ~periph_rst_n), 4'd0);
    end
  end

  task automatic wait_edge(input int k);
    int n = 0;
    while (edge_n < k && n < 2000) begin @(negedge clk); n++; end
  endtask

  task automatic wait_ready(input int limit);
    int n = 0;
    while (ready !== 1'b1 && n < limit) begin @(negedge clk); n++; end
    check("ready_timeout", 4'(ready), 4'd1);
  endtask

  int e, hs, lk_hold, bt_hold, rs_hold;

  initial begin
    rst_n = 0; pll_locked = 1; btn_reset = 0; sw_reset_req = 0;
    repeat (3) @(negedge clk);
    cmp_en = 1;
    check("por_periph", 4'(periph_rst_n), 4'd0);
    check("por_cpu", 4'(cpu_rst_n), 4'd0);
    check("por_ready", 4'(ready), 4'd0);
    check("por_cause", 4'(reset_cause), 4'd0);
    rst_n = 1;

    // Nominal release with lock already high.
    wait_edge(10); check("periph_e10", 4'(periph_rst_n), 4'd0);
    wait_edge(11); check("periph_e11", 4'(periph_rst_n), 4'd1);
    check("cpu_e11", 4'(cpu_rst_n), 4'd0);
    wait_edge(14); check("cpu_e14", 4'(cpu_rst_n), 4'd0);
    wait_edge(15); check("cpu_e15", 4'(cpu_rst_n), 4'd1);
    check("ready_e15", 4'(ready), 4'd1);
    check("cause_e15", 4'(reset_cause), 4'd0);

    // Software request in run: 64-cycle hold, then the lock sequence.
    sw_reset_req = 1; hs = edge_n + 1;
    @(negedge clk); sw_reset_req = 0;
    check("sw_periph", 4'(periph_rst_n), 4'd0);
    check("sw_ready", 4'(ready), 4'd0);
    check("sw_cause", 4'(reset_cause), 4'd3);
    wait_edge(hs + 72); check("sw_hold_periph_low", 4'(periph_rst_n), 4'd0);
    wait_edge(hs + 73); check("sw_hold_periph_high", 4'(periph_rst_n), 4'd1);
    sw_reset_req = 1;
    @(negedge clk); sw_reset_req = 0;
    check("sw_in_periph_ignored", 4'(periph_rst_n), 4'd1);
    wait_edge(hs + 76); check("sw_cpu_low", 4'(cpu_rst_n), 4'd0);
    wait_edge(hs + 77); check("sw_cpu_high", 4'(cpu_rst_n), 4'd1);

    // 40-cycle button press: reset 18 edges after press start.
    btn_reset = 1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i == 17) check("btn_ready_e17", 4'(ready), 4'd1);
      if (i == 18) begin
        check("btn_ready_e18", 4'(ready), 4'd0);
        check("btn_cause", 4'(reset_cause), 4'd2);
      end
    end
    btn_reset = 0;
    wait_ready(400);

    // Short glitch never reaches the debounced level.
    btn_reset = 1;
    repeat (10) @(negedge clk);
    btn_reset = 0;
    repeat (30) @(negedge clk);
    check("glitch_ready", 4'(ready), 4'd1);
    check("glitch_cause", 4'(reset_cause), 4'd2);

    // Lock loss and software request on the same edge: lock wins, no hold.
    pll_locked = 0; e = edge_n + 1;
    @(negedge clk);
    @(negedge clk);
    sw_reset_req = 1;
    @(negedge clk);
    sw_reset_req = 0; pll_locked = 1;
    check("same_edge_cause", 4'(reset_cause), 4'd1);
    check("same_edge_ready", 4'(ready), 4'd0);
    wait_edge(e + 12); check("same_edge_periph_low", 4'(periph_rst_n), 4'd0);
    wait_edge(e + 13); check("same_edge_periph_high", 4'(periph_rst_n), 4'd1);

    // rst_n in the peripheral phase restores every reset value.
    rst_n = 0;
    @(negedge clk);
    check("rst_periph", 4'(periph_rst_n), 4'd0);
    check("rst_cpu", 4'(cpu_rst_n), 4'd0);
    check("rst_cause", 4'(reset_cause), 4'd0);
    rst_n = 1;
    wait_ready(100);

    // Randomized lock drops, button presses, software pulses and resets.
    lk_hold = 0; bt_hold = 0; rs_hold = 0;
    for (int c = 0; c < 15000; c++) begin
      @(negedge clk);
      sw_reset_req = ($urandom_range(0, 149) == 0);
      if (lk_hold > 0) begin
        lk_hold--;
        if (lk_hold == 0) pll_locked = 1;
      end else if ($urandom_range(0, 499) == 0) begin
        pll_locked = 0; lk_hold = $urandom_range(1, 6);
      end
      if (bt_hold > 0) begin
        bt_hold--;
        if (bt_hold == 0) btn_reset = 0;
      end else if ($urandom_range(0, 699) == 0) begin
        btn_reset = 1; bt_hold = $urandom_range(1, 250);
      end
      if (rs_hold > 0) begin
        rs_hold--;
        if (rs_hold == 0) rst_n = 1;
      end else if ($urandom_range(0, 3999) == 0) begin
        rst_n = 0; rs_hold = $urandom_range(1, 3);
      end
    end
    pll_locked = 1; btn_reset = 0; sw_reset_req = 0; rst_n = 1;
    wait_ready(600);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
